// File: rtl/pci_ack_tracker.sv
// pci_ack_tracker: edge tracker for NUM_CH pci_ack lines.
//   A rising edge on a line sets a sticky status bit and bumps a saturating
//   counter for that line. Software reaches status, mask and counters through
//   a single-cycle register port. o_irq is the registered OR of unmasked status.
//
// Ports
//   i_clk        block clock, rising edge
//   i_rst        asynchronous reset, active low
//   i_pci_ack    [NUM_CH]  acknowledge lines (level)
//   i_reg_sel    access strobe, one cycle per access
//   i_reg_wr     1 = write, 0 = read
//   i_reg_addr   [ADDR_W]  word address: 0 STATUS (W1C), 1 MASK, 2+i CNT[i]
//   i_reg_wdata  [DATA_W]  write data
//   o_reg_rdata  [DATA_W]  read data, held between reads
//   o_reg_rvalid one-cycle read strobe, cycle after the read access
//   o_irq        level interrupt
//
// Build option
//   PCI_ACK_TRACKER_SYNC_EN : adds a 2-flop synchroniser per line ahead of
//   edge detection (two extra cycles of latency).

// Per-line logic: optional synchroniser, edge detect, sticky status, counter.
module pci_ack_lane #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ack,
  input  logic             i_clr_st,
  input  logic             i_clr_cnt,
  output logic             o_status,
  output logic [CNT_W-1:0] o_cnt
);
  logic             w_ack;
  logic             w_rise;
  logic             r_prev;
  logic             r_status;
  logic [CNT_W-1:0] r_cnt;

`ifdef PCI_ACK_TRACKER_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_ack};
  end
  assign w_ack = r_sync[1];
`else
  assign w_ack = i_ack;
`endif

  // r_prev resets to 0, so a line already high at reset release is an edge.
  assign w_rise = w_ack & ~r_prev;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prev   <= 1'b0;
      r_status <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_prev   <= w_ack;
      // Set beats clear when both land in the same cycle.
      r_status <= (r_status & ~i_clr_st) | w_rise;
      if (i_clr_cnt)
        r_cnt <= w_rise ? CNT_W'(1) : '0;
      else if (w_rise && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_status = r_status;
  assign o_cnt    = r_cnt;
endmodule

module pci_ack_tracker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_pci_ack,
  input  logic              i_reg_sel,
  input  logic              i_reg_wr,
  input  logic [ADDR_W-1:0] i_reg_addr,
  input  logic [DATA_W-1:0] i_reg_wdata,
  output logic [DATA_W-1:0] o_reg_rdata,
  output logic              o_reg_rvalid,
  output logic              o_irq
);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(1);

  logic                          w_wr;
  logic                          w_rd;
  logic [NUM_CH-1:0]             w_clr_st;
  logic [NUM_CH-1:0]             w_clr_cnt;
  logic [NUM_CH-1:0]             w_status;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt;
  logic [DATA_W-1:0]             w_rmux;
  logic                          w_unused_wdata;

  logic [NUM_CH-1:0] r_mask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  assign w_wr     = i_reg_sel &  i_reg_wr;
  assign w_rd     = i_reg_sel & ~i_reg_wr;
  assign w_clr_st = (w_wr && (i_reg_addr == A_STATUS)) ? i_reg_wdata[NUM_CH-1:0] : '0;

  // Counter writes clear regardless of data, so most wdata bits are don't-care.
  assign w_unused_wdata = ^i_reg_wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign w_clr_cnt[g] = w_wr && (i_reg_addr == ADDR_W'(g + 2));

    pci_ack_lane #(.CNT_W(CNT_W)) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_ack     (i_pci_ack[g]),
      .i_clr_st  (w_clr_st[g]),
      .i_clr_cnt (w_clr_cnt[g]),
      .o_status  (w_status[g]),
      .o_cnt     (w_cnt[g])
    );
  end

  // Read mux sees pre-update register values; unmapped addresses read 0.
  always_comb begin
    w_rmux = '0;
    if (i_reg_addr == A_STATUS) w_rmux[NUM_CH-1:0] = w_status;
    if (i_reg_addr == A_MASK)   w_rmux[NUM_CH-1:0] = r_mask;
    for (int i = 0; i < NUM_CH; i++)
      if (i_reg_addr == ADDR_W'(i + 2)) w_rmux[CNT_W-1:0] = w_cnt[i];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mask   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (i_reg_addr == A_MASK)) r_mask <= i_reg_wdata[NUM_CH-1:0];
      if (w_rd) r_rdata <= w_rmux;
      r_rvalid <= w_rd;
      r_irq    <= |(w_status & r_mask);
    end
  end

  assign o_reg_rdata  = r_rdata;
  assign o_reg_rvalid = r_rvalid;
  assign o_irq        = r_irq;
endmodule

// File: tb/tb_pci_ack_tracker.sv
module tb_pci_ack_tracker;
  logic        clk;
  logic        rst;
  logic [3:0]  ack;
  logic        sel;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  pci_ack_tracker #(.NUM_CH(4), .CNT_W(8), .ADDR_W(3), .DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pci_ack   (ack),
    .i_reg_sel   (sel),
    .i_reg_wr    (wr),
    .i_reg_addr  (addr),
    .i_reg_wdata (wdata),
    .o_reg_rdata (rdata),
    .o_reg_rvalid(rvalid),
    .o_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ack;
    logic        sel;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_irq;
  } vec_t;

  vec_t vec [29];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    check("write rvalid low", {31'd0, rvalid}, 32'd0);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    sel = 1'b1; wr = 1'b0; addr = a;
    tick();
    sel = 1'b0;
    check({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
    check(name, rdata, exp);
  endtask

  initial begin
    //          ack    sel  wr   addr  wdata   rvld  rdata  irq
    vec[0]  = '{4'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 1'b0}; // read STATUS after reset
    vec[1]  = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0}; // rvalid is one cycle wide
    vec[2]  = '{4'h0, 1'b1, 1'b1, 3'd1, 32'h2, 1'b0, 32'h0, 1'b0}; // MASK = 0010
    vec[3]  = '{4'h0, 1'b1, 1'b0, 3'd1, 32'h0, 1'b1, 32'h2, 1'b0};
    vec[4]  = '{4'h1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h2, 1'b0}; // rise ch0 (masked)
    vec[5]  = '{4'h1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h1, 1'b0};
    vec[6]  = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b0}; // masked ch0 -> no irq
    vec[7]  = '{4'h2, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b0}; // rise ch1
    vec[8]  = '{4'h2, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b1}; // irq two cycles after edge
    vec[9]  = '{4'h0, 1'b1, 1'b1, 3'd0, 32'h2, 1'b0, 32'h1, 1'b1}; // W1C bit1
    vec[10] = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b0}; // irq drops
    vec[11] = '{4'h0, 1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 32'h1, 1'b0}; // CNT0
    vec[12] = '{4'h0, 1'b1, 1'b0, 3'd3, 32'h0, 1'b1, 32'h1, 1'b0}; // CNT1
    vec[13] = '{4'h0, 1'b1, 1'b0, 3'd7, 32'h0, 1'b1, 32'h0, 1'b0}; // unmapped
    vec[14] = '{4'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h1, 1'b0}; // back-to-back 0,1,2,7
    vec[15] = '{4'h0, 1'b1, 1'b0, 3'd1, 32'h0, 1'b1, 32'h2, 1'b0};
    vec[16] = '{4'h0, 1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 32'h1, 1'b0};
    vec[17] = '{4'h0, 1'b1, 1'b0, 3'd7, 32'h0, 1'b1, 32'h0, 1'b0};
    vec[18] = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0};
    vec[19] = '{4'h0, 1'b1, 1'b1, 3'd0, 32'h1, 1'b0, 32'h0, 1'b0}; // clear bit0
    vec[20] = '{4'h1, 1'b1, 1'b1, 3'd0, 32'h1, 1'b0, 32'h0, 1'b0}; // W1C + rise ch0
    vec[21] = '{4'h1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h1, 1'b0}; // set wins
    vec[22] = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b0};
    vec[23] = '{4'h1, 1'b1, 1'b1, 3'd2, 32'h0, 1'b0, 32'h1, 1'b0}; // CNT0 clear + rise
    vec[24] = '{4'h1, 1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 32'h1, 1'b0}; // counter = 1
    vec[25] = '{4'h4, 1'b1, 1'b1, 3'd1, 32'h5, 1'b0, 32'h1, 1'b0}; // MASK write + rise ch2
    vec[26] = '{4'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1, 1'b1}; // new mask drives irq
    vec[27] = '{4'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 32'h5, 1'b1};
    vec[28] = '{4'h0, 1'b1, 1'b0, 3'd4, 32'h0, 1'b1, 32'h1, 1'b1}; // CNT2

    // Reset held with all lines high: nothing may be recorded.
    rst = 1'b0; ack = 4'hF; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    ack = 4'h0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 29; i++) begin
      ack = vec[i].ack; sel = vec[i].sel; wr = vec[i].wr;
      addr = vec[i].addr; wdata = vec[i].wdata;
      tick();
      check($sformatf("vec%0d rvalid", i), {31'd0, rvalid}, {31'd0, vec[i].e_rvalid});
      check($sformatf("vec%0d rdata", i), rdata, vec[i].e_rdata);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vec[i].e_irq});
    end
    sel = 1'b0; wr = 1'b0; ack = 4'h0;

    // Edge counting on ch2: three short pulses, then one long high.
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd0, 32'hF);
    for (int k = 0; k < 3; k++) begin
      ack = 4'h4; tick();
      ack = 4'h0; tick(); tick();
    end
    rd_chk("cnt2 three pulses", 3'd4, 32'd3);
    rd_chk("status ch2 only", 3'd0, 32'h4);
    ack = 4'h4;
    repeat (10) tick();
    ack = 4'h0;
    tick();
    rd_chk("cnt2 long high", 3'd4, 32'd4);

    // Saturation on ch0.
    wr_reg(3'd2, 32'h0);
    for (int k = 0; k < 300; k++) begin
      ack = 4'h1; tick();
      ack = 4'h0; tick();
    end
    rd_chk("cnt0 saturated", 3'd2, 32'd255);
    wr_reg(3'd2, 32'hFFFF_FFFF);
    rd_chk("cnt0 cleared", 3'd2, 32'd0);

    // Reset in the middle of a read.
    ack = 4'hF;
    tick(); tick();
    check("pre-reset irq", {31'd0, irq}, 32'd1);
    sel = 1'b1; wr = 1'b0; addr = 3'd0;
    tick();
    check("pre-reset rvalid", {31'd0, rvalid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async reset rvalid", {31'd0, rvalid}, 32'd0);
    check("async reset irq", {31'd0, irq}, 32'd0);
    check("async reset rdata", rdata, 32'd0);
    sel = 1'b0;
    repeat (2) tick();
    check("held reset irq", {31'd0, irq}, 32'd0);
    ack = 4'h0;
    rst = 1'b1;
    tick();
    rd_chk("post-reset status", 3'd0, 32'h0);
    tick();
    check("post-reset rvalid width", {31'd0, rvalid}, 32'd0);
    rd_chk("post-reset mask", 3'd1, 32'h0);
    rd_chk("post-reset cnt3", 3'd5, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pci_ack_tracker.md
Name: pci_ack_tracker

Overview:
- Parametrised acknowledge tracker for NUM_CH independent pci_ack lines.
- Per channel: detects rising edges, sets a sticky status bit and keeps a saturating event counter.
- Software accesses status, mask and counters through a simple register port (reg_sel/reg_wr).
- Drives a level interrupt to the host-side interrupt controller.

Parameters:
- NUM_CH, 4: number of pci_ack channels (1..32).
- CNT_W, 8: per-channel event counter width (1..32).
- ADDR_W, 3: register address width; requires NUM_CH+2 <= 2**ADDR_W.
- DATA_W, 32: register data width; requires NUM_CH <= DATA_W and CNT_W <= DATA_W.

Ports:
- clk  in  1  block clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- pci_ack  in  NUM_CH  acknowledge lines, one per channel, level.
- reg_sel  in  1  register access strobe, one cycle per access.
- reg_wr  in  1  1 = write, 0 = read; qualified by reg_sel.
- reg_addr  in  ADDR_W  register address.
- reg_wdata  in  DATA_W  write data.
- reg_rdata  out  DATA_W  read data, valid when reg_rvalid=1.
- reg_rvalid  out  1  one-cycle read-data strobe.
- irq  out  1  level interrupt, OR of unmasked status bits.

Behaviour:
- Reset (rst=0, asynchronous): status=0, mask=0, all counters=0, edge-history register=0, reg_rdata=0, reg_rvalid=0, irq=0.
- Edge detect: prev <= pci_ack every cycle; rise[i] = pci_ack[i] & ~prev[i].
  - A line already high at reset release counts as an edge on the first cycle.
- Status/counter update latency: rise in cycle N gives status[i]=1 and counter[i]+1 visible at cycle N+1. irq follows one cycle later (registered), at N+2.
- Counters saturate at 2**CNT_W-1; no wrap.
- Register map (word addresses):
  - 0 STATUS: NUM_CH bits, read; write-1-to-clear.
  - 1 MASK: NUM_CH bits, R/W; 1 = interrupt enabled.
  - 2+i CNT[i]: CNT_W bits, read; any write clears that counter.
  - Unused addresses: read 0, writes ignored.
  - Read data is zero-extended to DATA_W.
- Read handshake: reg_sel=1 & reg_wr=0 in cycle N gives reg_rdata valid with reg_rvalid=1 in cycle N+1 only. reg_rdata holds its value otherwise.
- Write: reg_sel=1 & reg_wr=1 in cycle N takes effect at N+1. reg_rvalid stays 0.
- Back-to-back accesses: one per cycle, no stall.
- Read value: reflects register contents before any same-cycle update (pre-update snapshot).
- Simultaneous events (same cycle):
  - STATUS W1C vs rise on the same bit: set wins, bit stays 1.
  - CNT clear vs rise on the same channel: counter becomes 1.
  - Write to MASK vs rise: both apply; irq uses the new mask from the next cycle.
- irq = |(status & mask), registered.
- Reset mid-operation: all state cleared immediately; an in-flight read is dropped (reg_rvalid=0).

Optional Feature:
- Macro PCI_ACK_TRACKER_SYNC_EN.
- Defined:
  - pci_ack passes through a 2-flop synchroniser per channel (reset to 0) before edge detection.
  - Status/counter latency grows to N+3 from the pin change; irq to N+4.
  - Pulses shorter than one clk period may be lost.
- Not defined: pci_ack feeds edge detection directly; latencies as in Behaviour.

Test Plan:
- Reset then idle: hold rst=0 mid-run with pci_ack=4'b1111 -> status=0, irq=0, reg_rvalid=0. Release with pci_ack=4'b0000, read addr 0 -> rdata=0 one cycle later, rvalid pulse of width 1.
- Edge count: pulse pci_ack[2] high 3 times (1 cycle high, 2 low each) -> CNT[2] (addr 4) reads 3, STATUS reads 4'b0100. Holding pci_ack[2] high for 10 cycles adds only 1.
- Saturation: CNT_W=8, 300 pulses on ch0 -> addr 2 reads 255. Write addr 2 -> reads 0.
- Interrupt/mask: MASK=4'b0010, rise on ch0 -> irq stays 0. Rise on ch1 -> irq=1 two cycles after the edge. W1C STATUS=4'b0010 -> irq=0 the cycle after status clears.
- Collision: W1C STATUS=4'b0001 in the same cycle as a ch0 rise -> STATUS bit0 stays 1. CNT[0] clear plus ch0 rise in the same cycle -> CNT[0]=1.
- Back-to-back reads: addrs 0,1,2,7 on consecutive cycles -> four consecutive rvalid pulses with the correct data; addr 7 returns 0 (NUM_CH=4).
